// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared opcodes, width default and arbiter state encoding
// Rev 1.0
`default_nettype none
package mul_arb_pkg;
  localparam int MUL_XLEN = 64;
  localparam int MUL_OPW  = 3;

  localparam logic [2:0] MO_MUL    = 3'd0;
  localparam logic [2:0] MO_MULH   = 3'd1;
  localparam logic [2:0] MO_MULHSU = 3'd2;
  localparam logic [2:0] MO_MULHU  = 3'd3;
  localparam logic [2:0] MO_MULW   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;
endpackage
`default_nettype wire

// File: rtl/mul_arb_rr.sv
// rr_arb2: two-way round-robin grant with pointer update on accept
// Rev 1.0
`default_nettype none
module rr_arb2
  import mul_arb_pkg::*;
(
  input  logic i_elig0,
  input  logic i_elig1,
  input  logic i_rr,
  input  logic i_accept,
  output logic o_grant,
  output logic o_rr_next
);
  always_comb begin
    o_grant = i_rr;
    if (i_elig0 && !i_elig1) begin
      o_grant = 1'b0;
    end else if (i_elig1 && !i_elig0) begin
      o_grant = 1'b1;
    end
    o_rr_next = i_accept ? ~o_grant : i_rr;
  end
endmodule
`default_nettype wire

// File: rtl/mul_arb.sv
// mul_arb: shares one iterative multiplier between two integer pipes.
// Optional MUL_ARB_BYPASS_EN returns an accepted result in the mul response cycle.
`default_nettype none
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int XLEN = MUL_XLEN,
  parameter int OPW  = MUL_OPW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req0_operand1,
  input  logic [XLEN-1:0] req0_operand2,
  input  logic [XLEN-1:0] req1_operand1,
  input  logic [XLEN-1:0] req1_operand2,
  input  logic [OPW-1:0]  req0_op,
  input  logic [OPW-1:0]  req1_op,
  input  logic            flush0,
  input  logic            flush1,
  output logic            resp0_valid,
  output logic            resp1_valid,
  input  logic            resp0_ready,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            mul_req_valid,
  input  logic            mul_req_ready,
  output logic [XLEN-1:0] mul_operand1,
  output logic [XLEN-1:0] mul_operand2,
  output logic [OPW-1:0]  mul_op,
  input  logic            mul_resp_valid,
  input  logic [XLEN-1:0] mul_resp_result
);
  arb_state_e      r_state, w_state_nxt;
  logic            r_rr, w_rr_nxt;
  logic            r_owner, w_owner_nxt;
  logic            r_killed, w_killed_nxt;
  logic            r_resp0_valid, w_resp0_valid_nxt;
  logic            r_resp1_valid, w_resp1_valid_nxt;
  logic [XLEN-1:0] r_resp_result, w_resp_result_nxt;

  logic w_idle, w_elig0, w_elig1, w_grant, w_accept;
  logic w_flush_own, w_ready_own, w_bypass;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_elig0     = req0_valid && !flush0;
  assign w_elig1     = req1_valid && !flush1;
  assign w_flush_own = r_owner ? flush1 : flush0;
  assign w_ready_own = r_owner ? resp1_ready : resp0_ready;

  rr_arb2 u_rr (
    .i_elig0   (w_elig0),
    .i_elig1   (w_elig1),
    .i_rr      (r_rr),
    .i_accept  (w_accept),
    .o_grant   (w_grant),
    .o_rr_next (w_rr_nxt)
  );

  assign mul_req_valid = w_idle && (w_elig0 || w_elig1);
  assign w_accept      = mul_req_valid && mul_req_ready;
  assign mul_operand1  = w_grant ? req1_operand1 : req0_operand1;
  assign mul_operand2  = w_grant ? req1_operand2 : req0_operand2;
  assign mul_op        = w_grant ? req1_op : req0_op;
  assign req0_ready    = w_idle && mul_req_ready && w_elig0 && !w_grant;
  assign req1_ready    = w_idle && mul_req_ready && w_elig1 && w_grant;

`ifdef MUL_ARB_BYPASS_EN
  assign w_bypass = (r_state == ST_BUSY) && mul_resp_valid && !r_killed
                    && !w_flush_own && w_ready_own;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed result is consumed in the same cycle, so it never touches the holding register.
  assign resp0_valid = r_resp0_valid || (w_bypass && !r_owner);
  assign resp1_valid = r_resp1_valid || (w_bypass && r_owner);
  assign resp_result = w_bypass ? mul_resp_result : r_resp_result;

  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_killed_nxt      = r_killed;
    w_resp0_valid_nxt = r_resp0_valid;
    w_resp1_valid_nxt = r_resp1_valid;
    w_resp_result_nxt = r_resp_result;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_owner_nxt  = w_grant;
          w_killed_nxt = 1'b0;
          w_state_nxt  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mul_resp_valid) begin
          if (r_killed || w_flush_own || w_bypass) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_resp_result_nxt = mul_resp_result;
            w_resp0_valid_nxt = !r_owner;
            w_resp1_valid_nxt = r_owner;
            w_state_nxt       = ST_RESP;
          end
        end else if (w_flush_own) begin
          w_killed_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (w_flush_own || w_ready_own) begin
          w_resp0_valid_nxt = 1'b0;
          w_resp1_valid_nxt = 1'b0;
          w_state_nxt       = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr          <= 1'b0;
      r_owner       <= 1'b0;
      r_killed      <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp_result <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr          <= w_rr_nxt;
      r_owner       <= w_owner_nxt;
      r_killed      <= w_killed_nxt;
      r_resp0_valid <= w_resp0_valid_nxt;
      r_resp1_valid <= w_resp1_valid_nxt;
      r_resp_result <= w_resp_result_nxt;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mul_arb.sv
// tb_mul_arb: directed bench with a multiplier stub and a transaction-level model of the arbiter.
`default_nettype none
module tb_mul_arb;
  import mul_arb_pkg::*;

`ifdef MUL_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [63:0] req0_operand1 = 0, req0_operand2 = 0, req1_operand1 = 0, req1_operand2 = 0;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic        flush0 = 0, flush1 = 0;
  logic        resp0_valid, resp1_valid, resp0_ready = 0, resp1_ready = 0;
  logic [63:0] resp_result;
  logic        mul_req_valid, mul_req_ready, mul_resp_valid;
  logic [63:0] mul_operand1, mul_operand2, mul_resp_result;
  logic [2:0]  mul_op;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_arb #(.XLEN(64), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_operand1(req0_operand1), .req0_operand2(req0_operand2),
    .req1_operand1(req1_operand1), .req1_operand2(req1_operand2),
    .req0_op(req0_op), .req1_op(req1_op),
    .flush0(flush0), .flush1(flush1),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_result(resp_result),
    .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
    .mul_operand1(mul_operand1), .mul_operand2(mul_operand2), .mul_op(mul_op),
    .mul_resp_valid(mul_resp_valid), .mul_resp_result(mul_resp_result)
  );

  function automatic logic [63:0] mul_calc(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  w;
    p = '0;
    w = '0;
    case (op)
      MO_MUL:    begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      MO_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      MO_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      MO_MULHU:  begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      MO_MULW:   begin w = {32'b0, a[31:0]} * {32'b0, b[31:0]}; return {{32{w[31]}}, w[31:0]}; end
      default:   return 64'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier stub: single slot, MULW answers 2 cycles after accept, everything else 5.
  logic        s_busy;
  int          s_cnt;
  logic [63:0] s_res;
  assign mul_req_ready   = !s_busy;
  assign mul_resp_valid  = s_busy && (s_cnt == 0);
  assign mul_resp_result = mul_resp_valid ? s_res : 64'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_busy <= 1'b0;
      s_cnt  <= 0;
      s_res  <= '0;
    end else if (s_busy) begin
      if (s_cnt == 0) s_busy <= 1'b0;
      else            s_cnt  <= s_cnt - 1;
    end else if (mul_req_valid) begin
      s_busy <= 1'b1;
      s_cnt  <= (mul_op == MO_MULW) ? 1 : 4;
      s_res  <= mul_calc(mul_op, mul_operand1, mul_operand2);
    end
  end

  // Model: one outstanding transaction; phase 0 = none, 1 = inside mul, 2 = result held.
  int          m_phase;
  bit          m_rr, m_owner, m_killed;
  logic [63:0] m_res;
  bit t_e0, t_e1, t_g, t_fown, t_rown, t_byp;
  assign t_e0   = req0_valid && !flush0;
  assign t_e1   = req1_valid && !flush1;
  assign t_g    = (t_e0 && t_e1) ? m_rr : t_e1;
  assign t_fown = m_owner ? flush1 : flush0;
  assign t_rown = m_owner ? resp1_ready : resp0_ready;
  assign t_byp  = BYP && (m_phase == 1) && mul_resp_valid && !m_killed && !t_fown && t_rown;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_rr     <= 1'b0;
      m_owner  <= 1'b0;
      m_killed <= 1'b0;
      m_res    <= '0;
    end else begin
      case (m_phase)
        0: if ((t_e0 || t_e1) && mul_req_ready) begin
             m_owner  <= t_g;
             m_rr     <= !t_g;
             m_killed <= 1'b0;
             m_res    <= t_g ? mul_calc(req1_op, req1_operand1, req1_operand2)
                             : mul_calc(req0_op, req0_operand1, req0_operand2);
             m_phase  <= 1;
           end
        1: if (mul_resp_valid) m_phase <= (m_killed || t_fown || t_byp) ? 0 : 2;
           else if (t_fown)    m_killed <= 1'b1;
        2: if (t_fown || t_rown) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_mrv, exp_v0, exp_v1;
      exp_mrv = (m_phase == 0) && (t_e0 || t_e1);
      exp_v0  = ((m_phase == 2) || t_byp) && !m_owner;
      exp_v1  = ((m_phase == 2) || t_byp) && m_owner;
      check("mul_req_valid", mul_req_valid, exp_mrv);
      check("req0_ready", req0_ready, (m_phase == 0) && mul_req_ready && t_e0 && !t_g);
      check("req1_ready", req1_ready, (m_phase == 0) && mul_req_ready && t_e1 && t_g);
      if (exp_mrv) begin
        check("mul_operand1", mul_operand1, t_g ? req1_operand1 : req0_operand1);
        check("mul_operand2", mul_operand2, t_g ? req1_operand2 : req0_operand2);
        check("mul_op", mul_op, t_g ? req1_op : req0_op);
      end
      check("resp0_valid", resp0_valid, exp_v0);
      check("resp1_valid", resp1_valid, exp_v1);
      if (exp_v0 || exp_v1) check("resp_result", resp_result, m_res);
      if (mul_resp_valid && m_phase != 1) begin
        n_fail++;
        $display("FAIL mul_resp_outside_busy: mul_resp_valid=1 with no op outstanding");
      end
    end
  end

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input bit port, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
    if (port) begin
      req1_valid = 1; req1_op = op; req1_operand1 = a; req1_operand2 = b;
    end else begin
      req0_valid = 1; req0_op = op; req0_operand1 = a; req0_operand2 = b;
    end
  endtask

  task automatic wait_grant(input bit port, output int t0);
    bit ok = 0;
    t0 = -100;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin ok = 1; t0 = cyc; end
    end
    if (!ok) timeout("grant");
  endtask

  task automatic wait_resp(input bit port, input int t0, output logic [63:0] res, output int lat);
    bit ok = 0;
    res = '0;
    lat = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (port ? resp1_valid : resp0_valid) begin ok = 1; lat = cyc - t0; res = resp_result; end
    end
    if (!ok) timeout("resp");
  endtask

  // Issue one op on a port; response consumed immediately (rdy=1) or one cycle late (rdy=0).
  task automatic do_op(input bit port, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit rdy, output logic [63:0] res,
                       output int lat);
    int t0;
    set_req(port, op, a, b);
    if (port) resp1_ready = rdy; else resp0_ready = rdy;
    wait_grant(port, t0);
    @(posedge clk); #1;
    if (port) req1_valid = 0; else req0_valid = 0;
    wait_resp(port, t0, res, lat);
    if (!rdy) begin
      @(posedge clk); #1;
      if (port) resp1_ready = 1; else resp0_ready = 1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] res;
    int          lat, t0, gc;
    int          grants[$];
    int          exp_g[4];
    int          n_r0, n_r1;
    bit          done;
    exp_g = '{0, 1, 0, 1};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp1_valid", resp1_valid, 0);
    check("rst_resp_result", resp_result, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single MULW on port 0
    do_op(0, MO_MULW, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1, res, lat);
    check("mulw_result", res, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mulw_latency", lat, BYP ? 2 : 3);

    // Both ports requesting continuously from reset
    rst_n = 1'b0;
    set_req(0, MO_MUL, 64'd2, 64'd3);
    set_req(1, MO_MUL, 64'd4, 64'd5);
    resp0_ready = 1; resp1_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_r0 = 0; n_r1 = 0; done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp0_valid) begin n_r0++; check("both_port0_result", resp_result, 64'd6); end
      if (resp1_valid) begin n_r1++; check("both_port1_result", resp_result, 64'd20); end
      done = (n_r0 + n_r1 == 4);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    if (grants.size() < 4) timeout("grant_seq");
    else for (int i = 0; i < 4; i++) check($sformatf("grant_seq_%0d", i), grants[i], exp_g[i]);
    check("both_resp_count", n_r0 + n_r1, 4);

    // Port 1 MULHU held while its owner is not ready; port 0 waits
    set_req(1, MO_MULHU, '1, '1);
    resp1_ready = 0; resp0_ready = 1;
    wait_grant(1, t0);
    @(posedge clk); #1 req1_valid = 0;
    wait_resp(1, t0, res, lat);
    check("mulhu_result", res, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) set_req(0, MO_MUL, 64'd1, 64'd1);
      @(negedge clk);
      check("hold_resp1_valid", resp1_valid, 1);
      check("hold_resp_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("hold_no_grant", req0_ready, 0);
    end
    @(posedge clk); #1 resp1_ready = 1;
    @(negedge clk);
    check("release_no_same_cycle_grant", req0_ready, 0);
    @(posedge clk); #1 resp1_ready = 0;
    @(negedge clk);
    check("grant_after_release", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    wait_resp(0, cyc, res, lat);
    check("post_hold_result", res, 64'd1);
    @(posedge clk); #1;

    // Flush of the owner during BUSY; pending port 1 granted after the discarded response
    set_req(0, MO_MUL, 64'd5, 64'd5);
    wait_grant(0, t0);
    @(posedge clk); #1;
    req0_valid = 0;
    set_req(1, MO_MUL, 64'd2, 64'd3);
    resp1_ready = 1;
    @(posedge clk); #1 flush0 = 1;
    @(posedge clk); #1 flush0 = 0;
    gc = -1;
    for (int i = 0; i < 20 && gc < 0; i++) begin
      @(negedge clk);
      if (resp0_valid) check("flushed_resp0_valid", resp0_valid, 0);
      if (req1_ready) gc = cyc;
    end
    if (gc < 0) timeout("flush_next_grant");
    else check("flush_next_grant_cycle", gc - t0, 6);
    @(posedge clk); #1 req1_valid = 0;
    wait_resp(1, gc, res, lat);
    check("after_flush_result", res, 64'd6);
    @(posedge clk); #1;

    // Asynchronous reset while BUSY
    set_req(0, MO_MUL, 64'd9, 64'd9);
    resp0_ready = 1;
    wait_grant(0, t0);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_resp0_valid", resp0_valid, 0);
    check("arst_resp1_valid", resp1_valid, 0);
    check("arst_resp_result", resp_result, 0);
    check("arst_mul_req_valid", mul_req_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(0, MO_MUL, 64'd7, 64'd6, 1, res, lat);
    check("post_reset_result", res, 64'd42);
    check("post_reset_latency", lat, BYP ? 5 : 6);

    // MULW 2x2 with owner ready, then with owner not ready
    do_op(0, MO_MULW, 64'd2, 64'd2, 1, res, lat);
    check("mulw_ready_result", res, 64'd4);
    check("mulw_ready_latency", lat, BYP ? 2 : 3);
    do_op(0, MO_MULW, 64'd2, 64'd2, 0, res, lat);
    check("mulw_notready_result", res, 64'd4);
    check("mulw_notready_latency", lat, 3);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
